acc_mbist_ctrl: RTL and testbench

- March C- memory BIST sequencer for the column-wise accumulator memory bank.
- Drives the accumulator's test-mode controls: test_mode, BIST_mode=0 (MBIST), wr_en, wr_addr, the broadcast test partial sum and the BIST read address.
- Checks every column's read data against the expected background and reports a per-column fail map, which feeds column repair/remap.
- Sits between the top-level self-test controller and the accumulator.

---
 rtl/acc_mbist_pkg.sv | 60 ++++++
 rtl/acc_mbist_ctrl_if.sv | 35 +++
 rtl/acc_mbist_cmp.sv | 132 +++++++++++++
 rtl/acc_mbist_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_acc_mbist_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/acc_mbist_pkg.sv
// acc_mbist_pkg -- shared types and helpers for the accumulator March C- BIST.
//   mbist_state_e : sequencer states. M0..M5 are encoded 0..5 so that the
//                   low three bits of the state give the march element number.
//   DIR_* / BG*   : element direction and data background constants.
//   psum_width    : partial-sum word width, 2*operand width + clog2(columns).
//   addr_width    : column memory address width, never below 1 bit.
//   elem_*        : per-element direction, read/write background and successor.
package acc_mbist_pkg;

  typedef enum logic [3:0] {
    M0    = 4'd0,
    M1    = 4'd1,
    M2    = 4'd2,
    M3    = 4'd3,
    M4    = 4'd4,
    M5    = 4'd5,
    DRAIN = 4'd6,
    DONE  = 4'd7,
    IDLE  = 4'd8
  } mbist_state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  localparam logic BG0      = 1'b0;
  localparam logic BG1      = 1'b1;

  function automatic int psum_width(input int data_w, input int cols);
    return 2 * data_w + $clog2(cols);
  endfunction

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic logic elem_dir(input mbist_state_e s);
    return (s == M3 || s == M4) ? DIR_DOWN : DIR_UP;
  endfunction

  function automatic logic elem_rd_bg(input mbist_state_e s);
    return (s == M2 || s == M4) ? BG1 : BG0;
  endfunction

  function automatic logic elem_wr_bg(input mbist_state_e s);
    return (s == M1 || s == M3) ? BG1 : BG0;
  endfunction

  function automatic mbist_state_e next_elem(input mbist_state_e s);
    mbist_state_e n;
    case (s)
      M0:      n = M1;
      M1:      n = M2;
      M2:      n = M3;
      M3:      n = M4;
      M4:      n = M5;
      default: n = IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/acc_mbist_ctrl_if.sv
// acc_mbist_ctrl_if -- test-mode connection between the BIST sequencer and
// the column accumulator bank.
//   test_mode_o  : accumulator test_mode
//   bist_mode_o  : accumulator BIST_mode (0 = MBIST)
//   wr_en_o      : broadcast write enable
//   wr_addr_o    : write address
//   test_data_o  : broadcast write background
//   rd_addr_o    : BIST read address
//   rd_data_i    : flat column read data, column i at [i*DATA_WIDTH +: DATA_WIDTH]
// master = sequencer side, slave = accumulator side.
interface acc_mbist_ctrl_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 19,
  parameter int COLS       = 8
) ();

  logic                       test_mode_o;
  logic                       bist_mode_o;
  logic                       wr_en_o;
  logic [ADDR_WIDTH-1:0]      wr_addr_o;
  logic [DATA_WIDTH-1:0]      test_data_o;
  logic [ADDR_WIDTH-1:0]      rd_addr_o;
  logic [DATA_WIDTH*COLS-1:0] rd_data_i;

  modport master (
    output test_mode_o, bist_mode_o, wr_en_o, wr_addr_o, test_data_o, rd_addr_o,
    input  rd_data_i
  );

  modport slave (
    input  test_mode_o, bist_mode_o, wr_en_o, wr_addr_o, test_data_o, rd_addr_o,
    output rd_data_i
  );

endinterface

// File: rtl/acc_mbist_cmp.sv
// acc_mbist_cmp -- read-token delay line and per-column comparator.
//   clk, rst_n : clock, async active-low reset (flushes the delay line)
//   clear      : clears fail_map (and the fail capture) on an accepted start
//   in_valid   : a BIST read is being launched this cycle
//   in_exp     : expected background of that read (0 = all 0s, 1 = all 1s)
//   in_addr    : read address            (ACC_MBIST_FAIL_ADDR_EN only)
//   in_elem    : march element 0..5      (ACC_MBIST_FAIL_ADDR_EN only)
//   rd_data    : flat column read data
//   fail_map   : sticky per-column mismatch flags
//   fail_valid/fail_addr/fail_elem : first mismatch capture (ACC_MBIST_FAIL_ADDR_EN)
module acc_mbist_cmp
  import acc_mbist_pkg::*;
#(
  parameter int COLS       = 8,
  parameter int W          = 19,
  parameter int ADDR_WIDTH = 3,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic                  in_exp,
`ifdef ACC_MBIST_FAIL_ADDR_EN
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [2:0]            in_elem,
`endif
  input  logic [W*COLS-1:0]     rd_data,
  output logic [COLS-1:0]       fail_map
`ifdef ACC_MBIST_FAIL_ADDR_EN
  ,
  output logic                  fail_valid,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem
`endif
);

  logic tok_v;
  logic tok_e;
`ifdef ACC_MBIST_FAIL_ADDR_EN
  logic [ADDR_WIDTH-1:0] tok_a;
  logic [2:0]            tok_m;
`endif

  // The token arrives in the same cycle as the matching read data.
  generate
    if (RD_LATENCY == 0) begin : g_direct
      assign tok_v = in_valid;
      assign tok_e = in_exp;
`ifdef ACC_MBIST_FAIL_ADDR_EN
      assign tok_a = in_addr;
      assign tok_m = in_elem;
`endif
    end else begin : g_delay
      logic [RD_LATENCY-1:0] v_sr;
      logic [RD_LATENCY-1:0] e_sr;
`ifdef ACC_MBIST_FAIL_ADDR_EN
      logic [RD_LATENCY-1:0][ADDR_WIDTH-1:0] a_sr;
      logic [RD_LATENCY-1:0][2:0]            m_sr;
`endif
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_sr <= '0;
          e_sr <= '0;
`ifdef ACC_MBIST_FAIL_ADDR_EN
          a_sr <= '0;
          m_sr <= '0;
`endif
        end else begin
          v_sr[0] <= in_valid;
          e_sr[0] <= in_exp;
`ifdef ACC_MBIST_FAIL_ADDR_EN
          a_sr[0] <= in_addr;
          m_sr[0] <= in_elem;
`endif
          for (int i = 1; i < RD_LATENCY; i++) begin
            v_sr[i] <= v_sr[i-1];
            e_sr[i] <= e_sr[i-1];
`ifdef ACC_MBIST_FAIL_ADDR_EN
            a_sr[i] <= a_sr[i-1];
            m_sr[i] <= m_sr[i-1];
`endif
          end
        end
      end
      assign tok_v = v_sr[RD_LATENCY-1];
      assign tok_e = e_sr[RD_LATENCY-1];
`ifdef ACC_MBIST_FAIL_ADDR_EN
      assign tok_a = a_sr[RD_LATENCY-1];
      assign tok_m = m_sr[RD_LATENCY-1];
`endif
    end
  endgenerate

  logic [COLS-1:0] col_fail;

  always_comb begin
    col_fail = '0;
    for (int i = 0; i < COLS; i++) begin
      col_fail[i] = tok_v && (rd_data[i*W +: W] != {W{tok_e}});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_map <= '0;
    end else if (clear) begin
      fail_map <= '0;
    end else begin
      fail_map <= fail_map | col_fail;
    end
  end

`ifdef ACC_MBIST_FAIL_ADDR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_valid <= 1'b0;
      fail_addr  <= '0;
      fail_elem  <= '0;
    end else if (clear) begin
      fail_valid <= 1'b0;
      fail_addr  <= '0;
      fail_elem  <= '0;
    end else if (|col_fail && !fail_valid) begin
      fail_valid <= 1'b1;
      fail_addr  <= tok_a;
      fail_elem  <= tok_m;
    end
  end
`endif

endmodule

// File: rtl/acc_mbist_ctrl.sv
// acc_mbist_ctrl -- March C- BIST sequencer for the column accumulator memories.
//   clk, rst_n : clock, async active-low reset
//   start      : one-cycle pulse, starts a test from IDLE or DONE
//   acc        : accumulator test-mode port (acc_mbist_ctrl_if.master)
//   busy       : test running (M0..DRAIN)
//   done       : test finished, held until the next start
//   pass       : with done, 1 iff no column failed
//   fail_map   : sticky per-column fail flags
// Optional build macro ACC_MBIST_FAIL_ADDR_EN adds fail_valid, fail_addr and
// fail_elem, capturing the address and march element of the first mismatch.
//
// state | meaning
// IDLE  | waiting for start, all outputs 0
// M0    | up,   w0
// M1    | up,   r0,w1 (read cycle then write cycle per address)
// M2    | up,   r1,w0
// M3    | down, r0,w1
// M4    | down, r1,w0
// M5    | up,   r0
// DRAIN | RD_LATENCY cycles for the last reads to be compared
// DONE  | result valid, waiting for start
module acc_mbist_ctrl
  import acc_mbist_pkg::*;
#(
  parameter int  SYSTOLIC_SIZE     = 8,
  parameter int  PARTIAL_SUM_WIDTH = psum_width(8, SYSTOLIC_SIZE),
  parameter int  PATTERN_NUMBER    = 1,
  parameter int  RD_LATENCY        = 1,  // 0..2
  localparam int DEPTH             = PATTERN_NUMBER * SYSTOLIC_SIZE,
  localparam int ADDR_WIDTH        = addr_width(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  acc_mbist_ctrl_if.master         acc,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [SYSTOLIC_SIZE-1:0] fail_map
`ifdef ACC_MBIST_FAIL_ADDR_EN
  ,
  output logic                     fail_valid,
  output logic [ADDR_WIDTH-1:0]    fail_addr,
  output logic [2:0]               fail_elem
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST       = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE        = ADDR_WIDTH'(1);
  localparam logic [1:0]            DRAIN_INIT = (RD_LATENCY > 0) ? 2'(RD_LATENCY - 1) : 2'd0;

  mbist_state_e            st, st_n;
  logic [ADDR_WIDTH-1:0]   addr, addr_n;
  logic                    ph, ph_n;       // 0 = read cycle, 1 = write cycle in M1..M4
  logic [1:0]              drain, drain_n;
  logic                    clear;
  logic                    at_term;
  logic [ADDR_WIDTH-1:0]   step;

  logic                         rd_cyc_n, wr_cyc_n;
  logic                         busy_n, done_n;
  logic [ADDR_WIDTH-1:0]        wr_addr_n, rd_addr_n;
  logic [PARTIAL_SUM_WIDTH-1:0] test_data_n;
  logic                         rd_exp_n;
  logic                         rd_v, rd_exp;

  assign at_term = (elem_dir(st) == DIR_UP) ? (addr == LAST) : (addr == '0);
  assign step    = (elem_dir(st) == DIR_UP) ? (addr + ONE) : (addr - ONE);

  always_comb begin
    st_n    = st;
    addr_n  = addr;
    ph_n    = ph;
    drain_n = drain;
    clear   = 1'b0;
    case (st)
      IDLE, DONE: begin
        if (start) begin
          st_n   = M0;
          addr_n = '0;
          ph_n   = 1'b0;
          clear  = 1'b1;
        end
      end
      M0: begin
        if (addr == LAST) begin
          st_n   = M1;
          addr_n = '0;
        end else begin
          addr_n = addr + ONE;
        end
      end
      M1, M2, M3, M4: begin
        if (!ph) begin
          ph_n = 1'b1;
        end else begin
          ph_n = 1'b0;
          if (at_term) begin
            st_n   = next_elem(st);
            addr_n = (elem_dir(next_elem(st)) == DIR_UP) ? '0 : LAST;
          end else begin
            addr_n = step;
          end
        end
      end
      M5: begin
        if (addr == LAST) begin
          addr_n = '0;
          if (RD_LATENCY == 0) begin
            st_n = DONE;
          end else begin
            st_n    = DRAIN;
            drain_n = DRAIN_INIT;
          end
        end else begin
          addr_n = addr + ONE;
        end
      end
      DRAIN: begin
        if (drain == '0) st_n = DONE;
        else             drain_n = drain - 2'd1;
      end
      default: st_n = IDLE;
    endcase
  end

  // Output values for the cycle that st_n/addr_n/ph_n describe, registered below.
  always_comb begin
    rd_cyc_n    = (st_n == M5) || ((st_n inside {M1, M2, M3, M4}) && !ph_n);
    wr_cyc_n    = (st_n == M0) || ((st_n inside {M1, M2, M3, M4}) && ph_n);
    busy_n      = (st_n != IDLE) && (st_n != DONE);
    done_n      = (st_n == DONE);
    rd_addr_n   = rd_cyc_n ? addr_n : '0;
    wr_addr_n   = wr_cyc_n ? addr_n : '0;
    test_data_n = wr_cyc_n ? {PARTIAL_SUM_WIDTH{elem_wr_bg(st_n)}} : '0;
    rd_exp_n    = rd_cyc_n ? elem_rd_bg(st_n) : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st              <= IDLE;
      addr            <= '0;
      ph              <= 1'b0;
      drain           <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      acc.test_mode_o <= 1'b0;
      acc.wr_en_o     <= 1'b0;
      acc.wr_addr_o   <= '0;
      acc.test_data_o <= '0;
      acc.rd_addr_o   <= '0;
      rd_v            <= 1'b0;
      rd_exp          <= 1'b0;
    end else begin
      st              <= st_n;
      addr            <= addr_n;
      ph              <= ph_n;
      drain           <= drain_n;
      busy            <= busy_n;
      done            <= done_n;
      acc.test_mode_o <= busy_n;
      acc.wr_en_o     <= wr_cyc_n;
      acc.wr_addr_o   <= wr_addr_n;
      acc.test_data_o <= test_data_n;
      acc.rd_addr_o   <= rd_addr_n;
      rd_v            <= rd_cyc_n;
      rd_exp          <= rd_exp_n;
    end
  end

  assign acc.bist_mode_o = 1'b0;
  assign pass            = done & ~|fail_map;

`ifdef ACC_MBIST_FAIL_ADDR_EN
  logic [3:0] st_bits;
  assign st_bits = st;
`endif

  acc_mbist_cmp #(
    .COLS       (SYSTOLIC_SIZE),
    .W          (PARTIAL_SUM_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_cmp (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (rd_v),
    .in_exp     (rd_exp),
`ifdef ACC_MBIST_FAIL_ADDR_EN
    .in_addr    (acc.rd_addr_o),
    .in_elem    (st_bits[2:0]),
`endif
    .rd_data    (acc.rd_data_i),
    .fail_map   (fail_map)
`ifdef ACC_MBIST_FAIL_ADDR_EN
    ,
    .fail_valid (fail_valid),
    .fail_addr  (fail_addr),
    .fail_elem  (fail_elem)
`endif
  );

endmodule

// File: tb/tb_acc_mbist_ctrl.sv
// tb_acc_mbist_ctrl -- directed bench for acc_mbist_ctrl with a behavioural
// 8-column, 8-word accumulator memory (1-cycle read latency) and switchable
// stuck-at / coupling faults.
module tb_acc_mbist_ctrl;

  localparam int N  = 8;
  localparam int W  = 19;
  localparam int D  = 8;
  localparam int AW = 3;
  localparam int L  = 1;
  localparam int RUN_CYCLES = 10 * D + L;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         busy, done, pass;
  logic [N-1:0] fail_map;
`ifdef ACC_MBIST_FAIL_ADDR_EN
  logic          fail_valid;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;
`endif

  int n_err = 0;
  int n_chk = 0;

  acc_mbist_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(W), .COLS(N)) acc ();

  acc_mbist_ctrl #(
    .SYSTOLIC_SIZE  (N),
    .PATTERN_NUMBER (1),
    .RD_LATENCY     (L)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .acc        (acc),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_map   (fail_map)
`ifdef ACC_MBIST_FAIL_ADDR_EN
    ,
    .fail_valid (fail_valid),
    .fail_addr  (fail_addr),
    .fail_elem  (fail_elem)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural memory bank with optional faults.
  logic [W-1:0]   mem [N][D];
  logic [W*N-1:0] rd_q;
  bit             sa1_en = 1'b0;
  bit             cpl_en = 1'b0;

  always @(posedge clk) begin
    for (int c = 0; c < N; c++) begin
      rd_q[c*W +: W] <= mem[c][acc.rd_addr_o] |
                        ((sa1_en && c == 3 && acc.rd_addr_o == 3'd5) ? W'(1) : W'(0));
      if (acc.wr_en_o) mem[c][acc.wr_addr_o] <= acc.test_data_o;
    end
    if (acc.wr_en_o && cpl_en && acc.wr_addr_o == 3'd2) mem[0][6] <= ~mem[0][6];
  end
  assign acc.rd_data_i = rd_q;

  // Per-cycle trace of the first run: {wr_en, wr_addr, rd_addr, data-if-writing}.
  logic [25:0] trace [128];
  int          tr_n = 0;
  bit          rec_en = 1'b0;

  always @(negedge clk) begin
    if (rec_en && busy && tr_n < 128) begin
      trace[tr_n] = {acc.wr_en_o, acc.wr_addr_o, acc.rd_addr_o,
                     acc.wr_en_o ? acc.test_data_o : {W{1'b0}}};
      tr_n++;
    end
  end

  // Expected March C- trace for DEPTH=8: cycle k of the busy window.
  function automatic logic [25:0] exp_trace(input int k);
    logic         we;
    logic [2:0]   wa, ra;
    logic [W-1:0] d;
    int           e, j, a;
    we = 1'b0; wa = 3'd0; ra = 3'd0; d = '0;
    if (k < 8) begin
      we = 1'b1;
      wa = 3'(k);
    end else if (k < 72) begin
      e = (k - 8) / 16 + 1;
      j = (k - 8) % 16;
      a = j / 2;
      if (e >= 3) a = 7 - a;
      if (j % 2 == 0) begin
        ra = 3'(a);
      end else begin
        we = 1'b1;
        wa = 3'(a);
        d  = (e == 1 || e == 3) ? {W{1'b1}} : {W{1'b0}};
      end
    end else if (k < 80) begin
      ra = 3'(k - 72);
    end
    return {we, wa, ra, d};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Wait for busy to drop; counts cycles including the one already started.
  task automatic wait_idle(input bit inject, output int cyc);
    cyc = 1;
    while (busy === 1'b1 && cyc < 500) begin
      start = (inject && cyc == 10) ? 1'b1 : 1'b0;
      step();
      if (busy === 1'b1 || cyc < 500) cyc++;
    end
    start = 1'b0;
    cyc = cyc - 1;
  endtask

  function automatic logic [63:0] all_outs();
    return {busy, done, pass, fail_map, acc.test_mode_o, acc.bist_mode_o,
            acc.wr_en_o, acc.wr_addr_o, acc.rd_addr_o, acc.test_data_o};
  endfunction

  int cyc;

  initial begin
    for (int c = 0; c < N; c++)
      for (int a = 0; a < D; a++)
        mem[c][a] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fail_map", fail_map, 0);
    chk("rst_all_outs", all_outs(), 0);
    step();
    rst_n = 1'b1;
    step();

    // Fault-free run with waveform trace
    rec_en = 1'b1;
    pulse_start();
    chk("busy_after_start", busy, 1);
    chk("test_mode_after_start", acc.test_mode_o, 1);
    wait_idle(1'b0, cyc);
    rec_en = 1'b0;
    chk("run1_cycles", cyc, RUN_CYCLES);
    chk("run1_done", done, 1);
    chk("run1_pass", pass, 1);
    chk("run1_fail_map", fail_map, 0);
    chk("run1_test_mode_off", acc.test_mode_o, 0);
    chk("trace_len", tr_n, RUN_CYCLES);
    for (int k = 0; k < RUN_CYCLES; k++) begin
      chk($sformatf("trace_c%0d", k), trace[k], exp_trace(k));
    end
    chk("m3_first_rd_addr", trace[40][21:19], 3'd7);
    repeat (5) step();
    chk("done_held", done, 1);

    // Stuck-at-1, column 3 bit 0 address 5
    sa1_en = 1'b1;
    pulse_start();
    chk("done_clr_on_start", done, 0);
    wait_idle(1'b0, cyc);
    sa1_en = 1'b0;
    chk("sa1_cycles", cyc, RUN_CYCLES);
    chk("sa1_fail_map", fail_map, 8'h08);
    chk("sa1_pass", pass, 0);
    chk("sa1_done", done, 1);
`ifdef ACC_MBIST_FAIL_ADDR_EN
    chk("sa1_fail_valid", fail_valid, 1);
    chk("sa1_fail_addr", fail_addr, 3'd5);
    chk("sa1_fail_elem", fail_elem, 3'd1);
`endif

    // Coupling fault: writing address 2 flips address 6 in column 0
    cpl_en = 1'b1;
    pulse_start();
    chk("fail_map_clr_on_start", fail_map, 0);
    wait_idle(1'b0, cyc);
    cpl_en = 1'b0;
    chk("cpl_cycles", cyc, RUN_CYCLES);
    chk("cpl_fail_map", fail_map, 8'h01);
    chk("cpl_pass", pass, 0);

    // start pulsed while busy is ignored
    pulse_start();
    wait_idle(1'b1, cyc);
    chk("inject_cycles", cyc, RUN_CYCLES);
    chk("inject_pass", pass, 1);
    chk("inject_fail_map", fail_map, 0);
    repeat (3) step();
    chk("inject_still_done", done, 1);

    // Reset in the middle of M2
    pulse_start();
    repeat (29) step();
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_async_outs", all_outs(), 0);
    @(negedge clk);
    chk("rst_mid_outs", all_outs(), 0);
    step();
    rst_n = 1'b1;
    step();
    chk("rst_mid_idle", {busy, done}, 2'b00);
    pulse_start();
    wait_idle(1'b0, cyc);
    chk("post_rst_cycles", cyc, RUN_CYCLES);
    chk("post_rst_pass", pass, 1);
    chk("post_rst_done", done, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
